// File: rtl/snn_inference_ctrl.sv
// snn_inference_ctrl: sequences one spiking-classifier inference (clear, stream frames, drain, argmax).
// Optional SNN_CTRL_COUNT_OUT_EN exposes the per-neuron spike counters on spike_counts.
module snn_inference_ctrl #(
   parameter int N_IN      = 7,
   parameter int N_OUT     = 3,
   parameter int T_STEPS   = 16,
   parameter int DRAIN_CYC = 3,
   parameter int CNT_W     = 5,
   parameter int CLS_W     = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             frame_valid,
   input  logic [N_IN-1:0]  frame_data,
   output logic             frame_ready,
   output logic [N_IN-1:0]  sp_out,
   output logic             neuron_reset,
   input  logic [N_OUT-1:0] out_spikes,
   output logic             busy,
   output logic             done,
   output logic [CLS_W-1:0] class_out,
   output logic             class_valid,
   output logic             underrun
`ifdef SNN_CTRL_COUNT_OUT_EN
   ,
   output logic [N_OUT*CNT_W-1:0] spike_counts
`endif
);
   localparam int SW = $clog2(T_STEPS > DRAIN_CYC ? T_STEPS : DRAIN_CYC) + 1;
   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DECIDE, DONE} state_t;
   state_t           state;
   logic [SW-1:0]    step;
   logic [CNT_W-1:0] cnt [N_OUT];
   logic [CLS_W-1:0] best;
   logic [CNT_W-1:0] best_cnt;
   assign neuron_reset = reset || state == CLEAR;
   assign busy         = state != IDLE;
   assign frame_ready  = state == RUN;
   assign done         = state == DONE;
   // strict compare keeps the lowest index on ties
   always_comb begin
      best     = '0;
      best_cnt = cnt[0];
      for (int i = 1; i < N_OUT; i++)
         if (cnt[i] > best_cnt) begin
            best     = CLS_W'(i);
            best_cnt = cnt[i];
         end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         step        <= '0;
         sp_out      <= '0;
         class_out   <= '0;
         class_valid <= 1'b0;
         underrun    <= 1'b0;
         for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
      end else begin
         sp_out <= '0;
         if (state == RUN || state == DRAIN)
            for (int i = 0; i < N_OUT; i++)
               if (out_spikes[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
         case (state)
            IDLE: if (start) begin
               state       <= CLEAR;
               class_valid <= 1'b0;
               underrun    <= 1'b0;
            end
            CLEAR: begin
               step  <= '0;
               state <= RUN;
               for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
            end
            RUN: begin
               sp_out <= frame_valid ? frame_data : '0;
               if (!frame_valid) underrun <= 1'b1;
               step  <= step == SW'(T_STEPS - 1) ? '0 : step + 1'b1;
               state <= step == SW'(T_STEPS - 1) ? DRAIN : RUN;
            end
            DRAIN: begin
               step  <= step + 1'b1;
               state <= step == SW'(DRAIN_CYC - 1) ? DECIDE : DRAIN;
            end
            DECIDE: begin
               class_out <= best;
               state     <= DONE;
            end
            DONE: begin
               class_valid <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef SNN_CTRL_COUNT_OUT_EN
   for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
      assign spike_counts[g*CNT_W +: CNT_W] = cnt[g];
   end
`endif
endmodule

// File: tb/tb_snn_inference_ctrl.sv
// tb_snn_inference_ctrl: directed + randomized bench; stub neurons are driven directly on out_spikes.
module tb_snn_inference_ctrl;
   logic       clk = 1'b0;
   logic       reset, start, frame_valid, frame_ready, neuron_reset, busy, done, class_valid, underrun;
   logic [6:0] frame_data, sp_out;
   logic [2:0] out_spikes;
   logic [1:0] class_out;
   int         checks = 0, errors = 0;
   always #5 clk = ~clk;
   snn_inference_ctrl #(.CNT_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .frame_valid(frame_valid), .frame_data(frame_data),
      .frame_ready(frame_ready), .sp_out(sp_out), .neuron_reset(neuron_reset), .out_spikes(out_spikes),
      .busy(busy), .done(done), .class_out(class_out), .class_valid(class_valid), .underrun(underrun)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, want);
      end
   endtask
   function automatic logic [18:0] rand_pat(input int k);
      logic [18:0] p = '0;
      while ($countones(p) < k) p[$urandom_range(18, 0)] = 1'b1;
      return p;
   endfunction
   // counts saturate at 15 (4-bit counters); argmax keeps the lowest index on ties
   function automatic int model_cls(input logic [18:0] p0, input logic [18:0] p1, input logic [18:0] p2);
      int n[3];
      int b = 0;
      n[0] = $countones(p0) > 15 ? 15 : $countones(p0);
      n[1] = $countones(p1) > 15 ? 15 : $countones(p1);
      n[2] = $countones(p2) > 15 ? 15 : $countones(p2);
      for (int i = 1; i < 3; i++) if (n[i] > n[b]) b = i;
      return b;
   endfunction
   // cycle 0 = start cycle; 1 CLEAR, 2..17 RUN, 18..20 DRAIN, 21 DECIDE, 22 DONE, 23 IDLE
   task automatic run_inf(input logic [18:0] p0, input logic [18:0] p1, input logic [18:0] p2, input logic [15:0] fv);
      logic [6:0] want_sp = '0;
      int cls = model_cls(p0, p1, p2);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      start       = 1'b1;
      frame_valid = 1'($urandom);
      frame_data  = 7'($urandom);
      out_spikes  = 3'($urandom);
      for (int c = 1; c <= 23; c++) begin
         @(negedge clk);
         chk("busy", busy, c <= 22);
         chk("frame_ready", frame_ready, c >= 2 && c <= 17);
         chk("neuron_reset", neuron_reset, c == 1);
         chk("done", done, c == 22);
         chk("sp_out", sp_out, want_sp);
         chk("class_valid", class_valid, c == 23);
         if (c == 1) chk("underrun_clr", underrun, 0);
         if (c >= 22) chk("class_out", class_out, cls);
         if (c == 23) chk("underrun", underrun, fv != 16'hffff);
         start       = c <= 22 ? 1'($urandom) : 1'b0;
         frame_valid = (c >= 2 && c <= 17) ? fv[c-2] : 1'($urandom);
         frame_data  = 7'($urandom);
         out_spikes  = (c >= 2 && c <= 20) ? {p2[c-2], p1[c-2], p0[c-2]} : 3'($urandom);
         want_sp     = (c >= 2 && c <= 17 && frame_valid) ? frame_data : '0;
      end
   endtask
   initial begin
      reset = 1'b1; start = 1'b0; frame_valid = 1'b0; frame_data = '0; out_spikes = '0;
      repeat (2) @(negedge clk);
      chk("rst_sp_out", sp_out, 0);
      chk("rst_frame_ready", frame_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_class_out", class_out, 0);
      chk("rst_class_valid", class_valid, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_neuron_reset", neuron_reset, 1);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_neuron_reset", neuron_reset, 0);
      run_inf(rand_pat(4), rand_pat(6), rand_pat(2), 16'hffff);
      run_inf(rand_pat(5), rand_pat(3), rand_pat(5), 16'hffff);
      run_inf(rand_pat(3), rand_pat(2), rand_pat(7), ~16'h0208);
      run_inf(rand_pat(10), rand_pat(10), 19'h7ffff, 16'hffff);
      run_inf('0, '0, '0, 16'hffff);
      // abort mid-RUN at step 7
      @(negedge clk);
      start = 1'b1; frame_valid = 1'b1; out_spikes = '0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         start      = 1'($urandom);
         frame_data = 7'($urandom);
         out_spikes = 3'($urandom);
      end
      reset = 1'b1;
      #1 chk("mid_neuron_reset", neuron_reset, 1);
      @(negedge clk);
      chk("mid_busy", busy, 0);
      chk("mid_sp_out", sp_out, 0);
      chk("mid_class_valid", class_valid, 0);
      chk("mid_frame_ready", frame_ready, 0);
      chk("mid_neuron_reset_hold", neuron_reset, 1);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("post_neuron_reset", neuron_reset, 0);
      chk("post_busy", busy, 0);
      run_inf(rand_pat(2), rand_pat(8), rand_pat(8), 16'hffff);
      repeat (4) run_inf(19'($urandom), 19'($urandom), 19'($urandom), 16'($urandom | ($urandom & $urandom)));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
